// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: shared allocator FSM states and defaults
package voice_alloc_pkg;
  localparam int DEF_NUM_VOICES = 4;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/voice_age_tracker.sv
// voice_age_tracker: per-voice age ranks (0 newest), touch moves a voice to newest, reports oldest
module voice_age_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_BW = $clog2(NUM_VOICES)
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              touch_i,
  input  logic [IDX_BW-1:0] idx_i,
  output logic [IDX_BW-1:0] oldest_idx_o
);
  logic [IDX_BW-1:0] rank [NUM_VOICES];
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i)
      for (int v = 0; v < NUM_VOICES; v++) rank[v] <= IDX_BW'(v);
    else if (touch_i)
      for (int v = 0; v < NUM_VOICES; v++)
        rank[v] <= IDX_BW'(v) == idx_i ? '0 : rank[v] < rank[idx_i] ? rank[v] + 1'b1 : rank[v];
  always_comb begin
    oldest_idx_o = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (rank[v] == IDX_BW'(NUM_VOICES - 1)) oldest_idx_o = IDX_BW'(v);
  end
endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator (retrigger, first free, steal oldest) driving an oscillator bank
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int IDX_BW = $clog2(NUM_VOICES)
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    evtValid_i,
  output logic                    evtReady_o,
  input  logic                    evtNoteOn_i,
  input  logic [7:0]              evtNote_i,
  input  logic [6:0]              evtVel_i,
  input  logic                    allNotesOff_i,
  output logic [8*NUM_VOICES-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]   voiceEnable_o,
  output logic [NUM_VOICES-1:0]   voicePhaseRst_o,
  output logic                    stolen_o
);
  localparam logic [IDX_BW:0] LAST = (IDX_BW + 1)'(NUM_VOICES);
  state_t state, state_d;
  logic [IDX_BW:0] idx;
  logic [IDX_BW-1:0] cur, m_idx, f_idx, oldest, tgt;
  logic ev_on, m_found, f_found, touch;
  logic [7:0] ev_note;
  logic [NUM_VOICES-1:0][7:0] notes;
  logic [NUM_VOICES-1:0] en, prst;
  logic stolen;
  assign cur = idx[IDX_BW-1:0];
  assign tgt = m_found ? m_idx : f_found ? f_idx : oldest;
  assign touch = state == COMMIT && !allNotesOff_i && ev_on;
  assign evtReady_o = state == IDLE;
  assign voiceNote_o = notes;
  assign voiceEnable_o = en;
  assign voicePhaseRst_o = prst;
  assign stolen_o = stolen;
  voice_age_tracker #(.NUM_VOICES(NUM_VOICES), .IDX_BW(IDX_BW)) u_age (
    .clk_i(clk_i),
    .nrst_i(nrst_i),
    .touch_i(touch),
    .idx_i(tgt),
    .oldest_idx_o(oldest)
  );
  // idx runs one past the last voice so the final scan result settles before COMMIT
  always_comb begin
    state_d = allNotesOff_i ? IDLE :
              state == IDLE ? (evtValid_i ? SCAN : IDLE) :
              state == SCAN ? (idx == LAST ? COMMIT : SCAN) : IDLE;
  end
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      state <= IDLE;
      idx <= '0;
      ev_on <= 1'b0;
      ev_note <= '0;
      m_found <= 1'b0;
      f_found <= 1'b0;
      m_idx <= '0;
      f_idx <= '0;
      notes <= '0;
      en <= '0;
      prst <= '0;
      stolen <= 1'b0;
    end else begin
      state <= state_d;
      prst <= '0;
      stolen <= 1'b0;
      if (allNotesOff_i)
        en <= '0;
      else
        case (state)
          IDLE:
            if (evtValid_i) begin
              ev_on <= evtNoteOn_i && |evtVel_i;
              ev_note <= evtNote_i;
              m_found <= 1'b0;
              f_found <= 1'b0;
              idx <= '0;
            end
          SCAN: begin
            idx <= idx + 1'b1;
            if (idx < LAST) begin
              if (!m_found && en[cur] && notes[cur] == ev_note) begin
                m_found <= 1'b1;
                m_idx <= cur;
              end
              if (!f_found && !en[cur]) begin
                f_found <= 1'b1;
                f_idx <= cur;
              end
            end
          end
          COMMIT:
            if (ev_on) begin
              notes[tgt] <= ev_note;
              en[tgt] <= 1'b1;
              prst[tgt] <= 1'b1;
              stolen <= !m_found && !f_found;
            end else if (m_found)
              en[m_idx] <= 1'b0;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: table-driven and scoreboarded checks of voice_alloc against a timestamp-based reference model
module tb_voice_alloc;
  localparam int N = 4;
  logic clk_i = 1'b0;
  logic nrst_i = 1'b0;
  logic evtValid_i = 1'b0;
  logic evtReady_o;
  logic evtNoteOn_i = 1'b0;
  logic [7:0] evtNote_i = '0;
  logic [6:0] evtVel_i = '0;
  logic allNotesOff_i = 1'b0;
  logic [8*N-1:0] voiceNote_o;
  logic [N-1:0] voiceEnable_o;
  logic [N-1:0] voicePhaseRst_o;
  logic stolen_o;
  voice_alloc #(.NUM_VOICES(N)) dut (
    .clk_i(clk_i),
    .nrst_i(nrst_i),
    .evtValid_i(evtValid_i),
    .evtReady_o(evtReady_o),
    .evtNoteOn_i(evtNoteOn_i),
    .evtNote_i(evtNote_i),
    .evtVel_i(evtVel_i),
    .allNotesOff_i(allNotesOff_i),
    .voiceNote_o(voiceNote_o),
    .voiceEnable_o(voiceEnable_o),
    .voicePhaseRst_o(voicePhaseRst_o),
    .stolen_o(stolen_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [8*N-1:0] notes;
    logic [N-1:0] en;
    logic [N-1:0] pr;
    logic st;
  } exp_t;
  typedef struct {
    logic on;
    logic [7:0] note;
    logic [6:0] vel;
    logic [N-1:0] pr;
    logic st;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[14];
  int n_chk = 0;
  int n_fail = 0;
  int acc = 0;
  logic [7:0] m_note[N];
  logic m_en[N];
  int m_last[N];
  int m_t;
  always @(posedge clk_i) if (nrst_i && evtValid_i && evtReady_o) acc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_note[v] = '0;
      m_en[v] = 1'b0;
      m_last[v] = -v;
    end
    m_t = 0;
  endtask
  task automatic model_ev(input logic on, input logic [7:0] note, input logic [6:0] vel);
    exp_t e;
    int t;
    e.pr = '0;
    e.st = 1'b0;
    t = -1;
    if (on && vel != 0) begin
      for (int v = 0; v < N; v++) if (t < 0 && m_en[v] && m_note[v] == note) t = v;
      for (int v = 0; v < N; v++) if (t < 0 && !m_en[v]) t = v;
      if (t < 0) begin
        t = 0;
        for (int v = 1; v < N; v++) if (m_last[v] < m_last[t]) t = v;
        e.st = 1'b1;
      end
      m_note[t] = note;
      m_en[t] = 1'b1;
      m_t++;
      m_last[t] = m_t;
      e.pr[t] = 1'b1;
    end else
      for (int v = 0; v < N; v++)
        if (t < 0 && m_en[v] && m_note[v] == note) begin
          t = v;
          m_en[v] = 1'b0;
        end
    for (int v = 0; v < N; v++) begin
      e.notes[8*v+:8] = m_note[v];
      e.en[v] = m_en[v];
    end
    sb.push_back(e);
  endtask
  task automatic send(input logic on, input logic [7:0] note, input logic [6:0] vel, input bit hold,
                      output logic [N-1:0] pr_o, output logic st_o);
    exp_t e;
    int k;
    model_ev(on, note, vel);
    @(negedge clk_i);
    evtValid_i = 1'b1;
    evtNoteOn_i = on;
    evtNote_i = note;
    evtVel_i = vel;
    @(posedge clk_i);
    #1;
    if (!hold) evtValid_i = 1'b0;
    k = 0;
    do begin
      @(posedge clk_i);
      #1;
      k++;
    end while (!evtReady_o && k < 20);
    evtValid_i = 1'b0;
    chk("latency", 64'(k), 64'(N + 2));
    e = sb.pop_front();
    chk("notes", 64'(voiceNote_o), 64'(e.notes));
    chk("enable", 64'(voiceEnable_o), 64'(e.en));
    chk("phase_rst", 64'(voicePhaseRst_o), 64'(e.pr));
    chk("stolen", 64'(stolen_o), 64'(e.st));
    pr_o = voicePhaseRst_o;
    st_o = stolen_o;
    @(posedge clk_i);
    #1;
    chk("pulse_len", 64'({voicePhaseRst_o, stolen_o}), 64'(0));
  endtask
  task automatic chk_model_state(input string name);
    logic [8*N-1:0] nv;
    logic [N-1:0] ev;
    for (int v = 0; v < N; v++) begin
      nv[8*v+:8] = m_note[v];
      ev[v] = m_en[v];
    end
    chk({name, "_notes"}, 64'(voiceNote_o), 64'(nv));
    chk({name, "_enable"}, 64'(voiceEnable_o), 64'(ev));
  endtask
  initial begin
    logic [N-1:0] pr;
    logic st;
    int a0;
    tbl[0]  = '{1'b1, 8'd60,  7'd100, 4'b0001, 1'b0};
    tbl[1]  = '{1'b1, 8'd64,  7'd100, 4'b0010, 1'b0};
    tbl[2]  = '{1'b1, 8'd67,  7'd100, 4'b0100, 1'b0};
    tbl[3]  = '{1'b1, 8'd71,  7'd100, 4'b1000, 1'b0};
    tbl[4]  = '{1'b1, 8'd72,  7'd100, 4'b0001, 1'b1};
    tbl[5]  = '{1'b1, 8'd64,  7'd90,  4'b0010, 1'b0};
    tbl[6]  = '{1'b1, 8'd64,  7'd0,   4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 8'd99,  7'd64,  4'b0000, 1'b0};
    tbl[8]  = '{1'b0, 8'd72,  7'd64,  4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 8'd50,  7'd100, 4'b0001, 1'b0};
    tbl[10] = '{1'b1, 8'd51,  7'd100, 4'b0010, 1'b0};
    tbl[11] = '{1'b1, 8'd52,  7'd100, 4'b0100, 1'b1};
    tbl[12] = '{1'b1, 8'd52,  7'd100, 4'b0100, 1'b0};
    tbl[13] = '{1'b1, 8'd200, 7'd100, 4'b1000, 1'b1};
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(evtReady_o), 64'(1));
    chk("rst_notes", 64'(voiceNote_o), 64'(0));
    chk("rst_enable", 64'(voiceEnable_o), 64'(0));
    chk("rst_phase_rst", 64'(voicePhaseRst_o), 64'(0));
    chk("rst_stolen", 64'(stolen_o), 64'(0));
    @(negedge clk_i);
    nrst_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].on, tbl[i].note, tbl[i].vel, 1'b0, pr, st);
      chk($sformatf("tbl%0d_target", i), 64'(pr), 64'(tbl[i].pr));
      chk($sformatf("tbl%0d_steal", i), 64'(st), 64'(tbl[i].st));
    end
    @(negedge clk_i);
    evtValid_i = 1'b1;
    evtNoteOn_i = 1'b1;
    evtNote_i = 8'd90;
    evtVel_i = 7'd100;
    @(posedge clk_i);
    #1;
    evtValid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    allNotesOff_i = 1'b1;
    @(posedge clk_i);
    #1;
    allNotesOff_i = 1'b0;
    for (int v = 0; v < N; v++) m_en[v] = 1'b0;
    chk("panic_ready", 64'(evtReady_o), 64'(1));
    chk("panic_pulse", 64'({voicePhaseRst_o, stolen_o}), 64'(0));
    chk_model_state("panic");
    repeat (8) @(posedge clk_i);
    #1;
    chk_model_state("panic_later");
    send(1'b1, 8'd80, 7'd100, 1'b0, pr, st);
    chk("after_panic_target", 64'(pr), 64'(4'b0001));
    a0 = acc;
    send(1'b1, 8'd81, 7'd100, 1'b1, pr, st);
    chk("held_valid_accepts", 64'(acc - a0), 64'(1));
    @(negedge clk_i);
    evtValid_i = 1'b1;
    evtNoteOn_i = 1'b1;
    evtNote_i = 8'd33;
    evtVel_i = 7'd100;
    @(posedge clk_i);
    #1;
    evtValid_i = 1'b0;
    @(posedge clk_i);
    #3;
    nrst_i = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 64'(evtReady_o), 64'(1));
    chk("midrst_pulse", 64'({voicePhaseRst_o, stolen_o}), 64'(0));
    chk_model_state("midrst");
    @(negedge clk_i);
    nrst_i = 1'b1;
    send(1'b1, 8'd60, 7'd100, 1'b0, pr, st);
    chk("postrst_target", 64'(pr), 64'(4'b0001));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
